// File: rtl/regfile_np_clr.sv
// Multi-port register file with a sequential clear engine and a per-register pending scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_np_clr #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_a,
  input  logic                     clr_req,
  output logic                     clr_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  clr_idx_q, clr_idx_d;
  logic [DEPTH-1:0]   pend_q, pend_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic busy;
  logic wr_ok;
  logic ps_ok;

  assign busy     = (state_q == CLEAR);
  assign clr_busy = busy;

  // Register 0 is neither writable nor markable when hard-wired to zero.
  assign wr_ok = we && !busy && !((ZERO_REG != 0) && (wa == '0));
  assign ps_ok = pend_set && !busy && !((ZERO_REG != 0) && (pend_a == '0));

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    pend_d    = pend_q;
    if (state_q == IDLE) begin
      if (clr_req) begin
        state_d   = CLEAR;
        clr_idx_d = '0;
      end
    end else begin
      pend_d[clr_idx_q] = 1'b0;
      clr_idx_d         = clr_idx_q + 1'b1;
      if (&clr_idx_q) state_d = IDLE;
    end
    if (wr_ok) pend_d[wa] = 1'b0;
    // A new producer supersedes the writer retiring in the same cycle.
    if (ps_ok) pend_d[pend_a] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      pend_q    <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (busy)       mem_q[clr_idx_q] <= '0;
    else if (wr_ok) mem_q[wa]        <= wd;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra_w;
    logic [DATA_W-1:0] rd_w;
    logic              pend_w;
    logic              hit;

    assign ra_w = ra[i*ADDR_W +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
    assign hit = wr_ok && (wa == ra_w);
`else
    assign hit = 1'b0;
`endif

    always_comb begin
      rd_w   = mem_q[ra_w];
      pend_w = pend_q[ra_w];
      if (busy) begin
        rd_w   = '0;
        pend_w = 1'b0;
      end else if ((ZERO_REG != 0) && (ra_w == '0)) begin
        rd_w   = '0;
        pend_w = 1'b0;
      end else if (hit) begin
        rd_w   = wd;
        pend_w = ps_ok && (pend_a == wa);
      end
    end

    assign rd[i*DATA_W +: DATA_W] = rd_w;
    assign rd_pend[i]             = pend_w;
  end

endmodule

// File: tb/tb_regfile_np_clr.sv
// Scoreboard bench for regfile_np_clr: stimulus queues expected outputs, a negedge monitor compares.
module tb_regfile_np_clr;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            we = 1'b0;
  logic [AW-1:0]   wa = '0;
  logic [DW-1:0]   wd = '0;
  logic [NR*AW-1:0] ra = '0;
  logic [NR*DW-1:0] rd;
  logic [NR-1:0]   rd_pend;
  logic            pend_set = 1'b0;
  logic [AW-1:0]   pend_a = '0;
  logic            clr_req = 1'b0;
  logic            clr_busy;

  regfile_np_clr #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
    .rd_pend(rd_pend), .pend_set(pend_set), .pend_a(pend_a), .clr_req(clr_req),
    .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [2*DW-1:0] rd;
    logic [1:0]     pend;
    logic           busy;
  } exp_t;

  exp_t q[$];
  logic chk = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic expect_o(input string nm, input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                          input logic [1:0] p, input logic b);
    exp_t e;
    e.name = nm;
    e.rd   = {r1, r0};
    e.pend = p;
    e.busy = b;
    q.push_back(e);
    chk = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk = 1'b0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra = {a1, a0};
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; wa = a; wd = d;
    step();
    we = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk) begin
      exp_t e;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL no_expectation: output presented with empty scoreboard");
      end else begin
        e = q.pop_front();
        if ({rd, rd_pend, clr_busy} !== {e.rd, e.pend, e.busy}) begin
          bad++;
          $display("FAIL %s: got rd=%h pend=%b busy=%b, want rd=%h pend=%b busy=%b",
                   e.name, rd, rd_pend, clr_busy, e.rd, e.pend, e.busy);
        end
      end
    end
  end

  initial begin
    step();
    // Reset and post-reset clear.
    expect_o("in_reset", 0, 0, 2'b00, 1'b1);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 32; c++) begin
      expect_o("post_reset_busy", 0, 0, 2'b00, 1'b1);
      step();
    end
    expect_o("post_reset_idle", 0, 0, 2'b00, 1'b0);
    step();

    // Write/read and zero register.
    wr(5, 32'hDEADBEEF);
    wr(31, 32'h12345678);
    set_ra(5, 31);
    expect_o("read_r5_r31", 32'hDEADBEEF, 32'h12345678, 2'b00, 1'b0);
    step();
    we = 1'b1; wa = 0; wd = 32'hFFFFFFFF; set_ra(0, 5);
    expect_o("zero_write_cycle", 0, 32'hDEADBEEF, 2'b00, 1'b0);
    step();
    we = 1'b0;
    expect_o("zero_reads_zero", 0, 32'hDEADBEEF, 2'b00, 1'b0);
    step();

    // Scoreboard.
    pend_set = 1'b1; pend_a = 7;
    step();
    pend_set = 1'b0;
    set_ra(7, 7);
    expect_o("pend_r7", 0, 0, 2'b11, 1'b0);
    step();
    pend_set = 1'b1; pend_a = 7; we = 1'b1; wa = 7; wd = 32'hA5;
`ifdef REGFILE_BYPASS_EN
    expect_o("set_and_write_same_cycle", 32'hA5, 32'hA5, 2'b11, 1'b0);
`else
    expect_o("set_and_write_same_cycle", 0, 0, 2'b11, 1'b0);
`endif
    step();
    pend_set = 1'b0; we = 1'b0;
    expect_o("set_wins_over_write", 32'hA5, 32'hA5, 2'b11, 1'b0);
    step();
    wr(7, 32'h5A);
    expect_o("write_clears_pend", 32'h5A, 32'h5A, 2'b00, 1'b0);
    step();
    pend_set = 1'b1; pend_a = 0;
    step();
    pend_set = 1'b0;
    set_ra(0, 7);
    expect_o("pend_r0_ignored", 0, 32'h5A, 2'b00, 1'b0);
    step();

    // Write-to-read forwarding versus read-first.
    set_ra(9, 5);
    we = 1'b1; wa = 9; wd = 32'h11;
`ifdef REGFILE_BYPASS_EN
    expect_o("bypass_same_cycle", 32'h11, 32'hDEADBEEF, 2'b00, 1'b0);
`else
    expect_o("bypass_same_cycle", 0, 32'hDEADBEEF, 2'b00, 1'b0);
`endif
    step();
    we = 1'b0;
    expect_o("bypass_next_cycle", 32'h11, 32'hDEADBEEF, 2'b00, 1'b0);
    step();

    // Requested clear with writes, pend_set and a second request during it.
    for (int i = 1; i < 32; i++) wr(AW'(i), 32'(i) * 32'h01010101);
    set_ra(1, 31);
    expect_o("filled_r1_r31", 32'h01010101, 32'h1F1F1F1F, 2'b00, 1'b0);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 0; c < 32; c++) begin
      we = (c == 5); wa = 3; wd = 32'hBAD0BAD0;
      pend_set = (c == 6); pend_a = 4;
      clr_req = (c == 20);
      expect_o("req_clear_busy", 0, 0, 2'b00, 1'b1);
      step();
    end
    we = 1'b0; pend_set = 1'b0; clr_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_ra(AW'(2*i), AW'(2*i+1));
      expect_o("after_req_clear", 0, 0, 2'b00, 1'b0);
      step();
    end

    // Reset asserted at clear cycle 10.
    wr(20, 32'hCAFEF00D);
    set_ra(20, 2);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      expect_o("pre_reset_clear_busy", 0, 0, 2'b00, 1'b1);
      step();
    end
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      expect_o("mid_clear_reset", 0, 0, 2'b00, 1'b1);
      step();
    end
    rst_n = 1'b1;
    for (int c = 0; c < 32; c++) begin
      expect_o("restart_clear_busy", 0, 0, 2'b00, 1'b1);
      step();
    end
    expect_o("restart_clear_done", 0, 0, 2'b00, 1'b0);
    step();

    step();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_np_clr.md
Name: regfile_np_clr

Overview:
- Parametrised successor of the single-cycle core's 2-read/1-write register file.
- Configurable data width, depth and read-port count; register 0 optionally hard-wired to zero.
- Adds a sequential hardware-clear engine that runs after reset or on request, and a per-register pending scoreboard for multi-cycle producers.
- Sits between decode (read ports) and writeback (write port) of the next-generation pipelined core.

Parameters:
- DATA_W, 32, width of each register in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and never goes pending

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- we  in  1  write enable
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- ra  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd  out  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
- rd_pend  out  NUM_RD  port i's addressed register is pending
- pend_set  in  1  mark register pend_a pending
- pend_a  in  ADDR_W  register to mark pending
- clr_req  in  1  request full clear, single-cycle pulse
- clr_busy  out  1  clear engine active; writes and pend_set ignored

Behaviour:
- States: IDLE, CLEAR. Reset is asynchronous and active-low: clk is the single clock, rst_n clears asynchronously.
- While rst_n = 0:
  - state = CLEAR, clr_idx = 0, all pending bits = 0.
  - clr_busy = 1, rd = 0, rd_pend = 0.
  - Array contents are not reset directly.
- CLEAR state:
  - Each cycle writes 0 to regData[clr_idx] and clears its pending bit, then clr_idx increments.
  - When clr_idx = DEPTH-1 is written, next state = IDLE and clr_busy drops on that edge.
  - A full clear takes exactly DEPTH cycles from rst_n release or from the clr_req edge.
- IDLE state:
  - clr_req = 1 at an edge -> CLEAR with clr_idx = 0. clr_busy rises the cycle after the request.
  - clr_req is ignored while already in CLEAR; no restart.
- Behaviour while clr_busy = 1:
  - we and pend_set are ignored.
  - All rd outputs = 0 and all rd_pend = 0.
- Write:
  - we = 1 in IDLE writes wd to regData[wa] at the edge.
  - With ZERO_REG = 1, writes to wa = 0 are dropped.
- Read:
  - Combinational, zero latency.
  - With ZERO_REG = 1, ra = 0 returns 0.
  - Otherwise returns regData[ra] (see Optional Feature for same-cycle forwarding).
- Scoreboard:
  - pend_set = 1 in IDLE sets pend[pend_a] at the edge.
  - A write (we = 1) clears pend[wa] at the edge.
  - pend_set and we to the same address in the same cycle: set wins, because the new producer supersedes the old one; data is still written.
  - pend_a = 0 with ZERO_REG = 1 is ignored.
  - rd_pend[i] = pend[ra_i] combinationally.
- Multiple read ports may address the same register; each returns identical data.
- Reset asserted mid-clear restarts the engine at index 0 on release.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-first forwarding): if we = 1, not clr_busy, wa == ra_i, and wa is writable, then rd_i = wd in the same cycle and rd_pend[i] = 0. This holds unless pend_set targets the same address that cycle, in which case rd_pend[i] = 1.
- Undefined (read-first): rd_i returns the old array value until the edge, and rd_pend reflects the current pend bits.

Test Plan:
- Post-reset clear: release rst_n, DEPTH=32 -> clr_busy = 1 for exactly 32 cycles, rd = 0 throughout. Afterwards all 32 registers read 0 and rd_pend = 0.
- Write/read: write 0xDEADBEEF to r5, 0x12345678 to r31; read ra0 = 5, ra1 = 31 next cycle -> rd0 = 0xDEADBEEF, rd1 = 0x12345678. Write 0xFFFFFFFF to r0 -> ra = 0 reads 0.
- Scoreboard: pend_set r7 -> rd_pend = 1 for ra = 7. Then pend_set r7 and we r7 = 0xA5 in the same cycle -> still pending, data = 0xA5. Next write r7 = 0x5A -> rd_pend = 0.
- Requested clear mid-run: fill r1..r31 with nonzero values, pulse clr_req, assert we on r3 during the clear -> write ignored, clr_busy high for 32 cycles, all registers read 0 afterwards.
- Reset mid-clear: pulse clr_req, assert rst_n = 0 at clear cycle 10 for 2 cycles -> clear restarts and clr_busy stays high for 32 cycles after release.
- Bypass, both builds: we r9 = 0x11 while ra0 = 9 -> with REGFILE_BYPASS_EN, rd0 = 0x11 that cycle. Without it, rd0 shows the old value and updates to 0x11 next cycle.
